range_frame_sequencer: RTL and testbench
========================================

Name: range_frame_sequencer

Overview:
- Upstream feeder for the range-finder stage. Converts a bursty valid/ready sample stream with end-of-frame markers into a gap-free go/data/finish burst that the range finder can consume every cycle.
- Buffers a whole frame, then replays it contiguously: go on the first sample, finish on the last.
- Oversize frames are dropped and counted.

Parameters:
- WIDTH, 16, sample width; equals the range finder's WIDTH.
- DEPTH, 16, maximum frame length in samples; must be 2 or more.

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_data  in  WIDTH  input sample
- in_valid  in  1  in_data valid
- in_last  in  1  marks the final sample of a frame
- in_ready  out  1  sequencer can accept a beat
- data_out  out  WIDTH  sample to the range finder
- go  out  1  frame start, high with the first sample
- finish  out  1  frame end, high with the last sample
- busy  out  1  high while state is REPLAY
- drop  out  1  one-cycle pulse when an oversize frame is discarded
- drop_count  out  8  saturating count of dropped frames

Behaviour:
- Beat accepted = in_valid & in_ready on a rising clock edge.
- States:
  - FILL: in_ready=1. Write accepted beats at wr_cnt and increment wr_cnt.
    - Last beat accepted with wr_cnt+1 <= DEPTH: latch len=wr_cnt+1 and go to REPLAY.
    - Non-last beat accepted at wr_cnt==DEPTH-1 (buffer now full): go to DISCARD.
  - REPLAY: in_ready=0. Read index rd runs 0..len-1, one per cycle.
    - After the final index, return to FILL with wr_cnt=0.
  - DISCARD: in_ready=1. Consume beats without storing.
    - On the accepted last beat: pulse drop next cycle, increment drop_count (saturate at 255), go to FILL with wr_cnt=0.
- Output registers: data_out, go and finish are registered.
  - If the last beat is accepted at edge E, then go=1 and data_out=sample0 are valid after edge E+2.
  - Following samples appear one per cycle with no bubbles.
  - finish=1 appears with sample len-1.
  - go and finish are never high in the same cycle.
- Single-sample frame (len=1): two output cycles.
  - Cycle 1: go=1, data_out=s0.
  - Cycle 2: finish=1, data_out=s0. The range finder reports 0.
- Frame of exactly DEPTH samples with in_last on beat DEPTH-1 is legal and replays normally.
- Between frames, go, finish and data_out hold 0. data_out returns to 0 the cycle after finish.
- The earliest next go is 2 cycles after the next frame's last beat. The range finder accepts go from DONE, so back-to-back frames are legal.
- in_valid=0 mid-frame is allowed during FILL; it only delays the burst.
- in_last while in_valid=0 is ignored.
- Reset (any time, including mid-REPLAY or mid-DISCARD):
  - state=FILL, wr_cnt=0, rd=0, len=0.
  - go=0, finish=0, data_out=0, busy=0, drop=0, drop_count=0.
  - in_ready=0 while reset is asserted, and 1 from the first cycle after deassertion.
  - Buffer contents are not reset.
- wr_cnt, rd and len are $clog2(DEPTH+1) bits wide.

Optional Feature:
- Macro: RANGE_SEQ_TRUNC_EN.
- Defined: an oversize frame is truncated, not dropped.
  - The DEPTH-th beat without in_last is treated as the last beat: len=DEPTH, enter REPLAY, and a trunc flag is set.
  - After REPLAY, if trunc is set, enter DISCARD to swallow the remainder of the frame.
  - drop pulses and drop_count increments on the remainder's last beat, exactly as in drop mode.
- Not defined: oversize frames go directly to DISCARD with no output burst.

Decomposition:
- Package range_seq_pkg holds:
  - the state enum {FILL, REPLAY, DISCARD}, 2 bits;
  - localparam DROP_CNT_W=8.
- One sub-module: range_frame_buf, a DEPTH x WIDTH register array with a single write port and an asynchronous read port. No reset.
- The sequencer holds the FSM, counters and output registers.

Test Plan:
- WIDTH=16, DEPTH=4. Frame {5,9,2} with in_last on 2, valid every cycle -> go with 5, then 9, then finish with 2, contiguous; in_ready=0 for 3 cycles of REPLAY.
- Single beat {7, last} -> go/7 then finish/7. A range finder attached to the outputs reports range=0, error=0.
- Frame of 4 beats {1,2,3,4}, last on 4 -> full replay, finish with 4, drop stays 0.
- 6-beat frame, no truncation -> no go. drop pulses once after beat 6; drop_count=1; next frame {3,8} replays correctly. With RANGE_SEQ_TRUNC_EN: replay {s0..s3} with finish on s3, then drop=1 after beat 6.
- Frame {4,6,1} with in_valid toggled 1,0,1,0,1 -> output burst still gap-free.
- Assert reset during REPLAY after 2 of 4 samples -> go, finish and data_out are 0 immediately. After release: in_ready=1, drop_count=0, new frame {2,3} replays cleanly.

Source files
------------

// File: rtl/range_seq_pkg.sv
// Shared types for the range-finder frame sequencer: FSM state encoding and drop counter width.
package range_seq_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    REPLAY  = 2'd1,
    DISCARD = 2'd2
  } seq_state_t;

  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/range_frame_buf.sv
// Frame storage for the sequencer: DEPTH x WIDTH registers, one write port, asynchronous read.
module range_frame_buf
  import range_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/range_frame_sequencer.sv
// Buffers one frame and replays it as a gap-free go/data/finish burst for the range finder.
// Define RANGE_SEQ_TRUNC_EN to truncate oversize frames to DEPTH samples instead of dropping them.
module range_frame_sequencer
  import range_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      data_out,
  output logic                  go,
  output logic                  finish,
  output logic                  busy,
  output logic                  drop,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  seq_state_t       state;
  logic [CW-1:0]    wr_cnt;
  logic [CW-1:0]    rd;
  logic [CW-1:0]    len;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] st_data;
  logic             st_valid;
  logic             st_first;
  logic             st_last;
  logic             fin_pend;
  logic             accept;
  logic             wr_en;
`ifdef RANGE_SEQ_TRUNC_EN
  logic             trunc;
`endif

  assign in_ready = !reset && (state != REPLAY);
  assign busy     = (state == REPLAY);
  assign accept   = in_valid && in_ready;
  assign wr_en    = accept && (state == FILL);

  range_frame_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt[AW-1:0]),
    .wr_data (in_data),
    .rd_addr (rd[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      wr_cnt     <= '0;
      rd         <= '0;
      len        <= '0;
      drop       <= 1'b0;
      drop_count <= '0;
`ifdef RANGE_SEQ_TRUNC_EN
      trunc      <= 1'b0;
`endif
    end else begin
      drop <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (in_last) begin
              len    <= wr_cnt + 1'b1;
              rd     <= '0;
              wr_cnt <= '0;
              state  <= REPLAY;
            end else if (wr_cnt == LAST_IDX) begin
              wr_cnt <= '0;
`ifdef RANGE_SEQ_TRUNC_EN
              len    <= CW'(DEPTH);
              rd     <= '0;
              trunc  <= 1'b1;
              state  <= REPLAY;
`else
              state  <= DISCARD;
`endif
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        REPLAY: begin
          if (rd == len - 1'b1) begin
            rd    <= '0;
`ifdef RANGE_SEQ_TRUNC_EN
            state <= trunc ? DISCARD : FILL;
            trunc <= 1'b0;
`else
            state <= FILL;
`endif
          end else begin
            rd <= rd + 1'b1;
          end
        end
        DISCARD: begin
          if (accept && in_last) begin
            drop   <= 1'b1;
            wr_cnt <= '0;
            state  <= FILL;
            if (drop_count != '1) begin
              drop_count <= drop_count + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Two-stage output path; a one-sample frame needs an extra finish cycle so go and finish never coincide.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_valid <= 1'b0;
      st_first <= 1'b0;
      st_last  <= 1'b0;
      st_data  <= '0;
      fin_pend <= 1'b0;
      data_out <= '0;
      go       <= 1'b0;
      finish   <= 1'b0;
    end else begin
      st_valid <= busy;
      st_data  <= busy ? rd_data : '0;
      st_first <= (rd == '0);
      st_last  <= (rd == len - 1'b1);
      if (fin_pend) begin
        go       <= 1'b0;
        finish   <= 1'b1;
        fin_pend <= 1'b0;
      end else if (st_valid) begin
        data_out <= st_data;
        go       <= st_first;
        finish   <= st_last && !st_first;
        fin_pend <= st_first && st_last;
      end else begin
        data_out <= '0;
        go       <= 1'b0;
        finish   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_range_frame_sequencer.sv
// Scoreboard bench for range_frame_sequencer (WIDTH=16, DEPTH=4); honours RANGE_SEQ_TRUNC_EN.
module tb_range_frame_sequencer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  typedef logic [WIDTH-1:0] sample_t;
  typedef struct {
    sample_t data;
    logic    go;
    logic    fin;
    int      cyc;
  } beat_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic             busy;
  logic             drop;
  logic [7:0]       drop_count;

  beat_t sb[$];
  int    busy_q[$];
  beat_t e;
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    popped = 0;
  int    busy_run = 0;
  int    model_drops = 0;

  range_frame_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .go         (go),
    .finish     (finish),
    .busy       (busy),
    .drop       (drop),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference behaviour: a kept frame reappears two cycles after its closing beat, one sample per cycle.
  task automatic pushBurst(input sample_t fr[$], input int n, input int base);
    beat_t b;
    if (n == 1) begin
      b = '{data: fr[0], go: 1'b1, fin: 1'b0, cyc: base};
      sb.push_back(b);
      b = '{data: fr[0], go: 1'b0, fin: 1'b1, cyc: base + 1};
      sb.push_back(b);
    end else begin
      for (int k = 0; k < n; k++) begin
        b = '{data: fr[k], go: (k == 0), fin: (k == n - 1), cyc: base + k};
        sb.push_back(b);
      end
    end
    busy_q.push_back(n);
  endtask

  task automatic applyStimulus(input sample_t fr[$], input int gap_mode, output bit ok);
    int  n = fr.size();
    int  i = 0;
    int  waits;
    int  c;
    bit  alt = 1'b0;
    ok = 1'b1;
    while (i < n) begin
      @(negedge clock);
      if ((gap_mode == 1 && alt) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        in_data  = sample_t'($urandom);
        in_last  = 1'($urandom_range(0, 1));
        alt      = 1'b0;
        @(posedge clock);
        continue;
      end
      alt      = 1'b1;
      in_valid = 1'b1;
      in_data  = fr[i];
      in_last  = (i == n - 1);
      waits    = 0;
      while (!in_ready && waits < 200) begin
        @(posedge clock);
        @(negedge clock);
        waits++;
      end
      if (!in_ready) begin
        checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
        ok = 1'b0;
        return;
      end
      c = cyc;
      @(posedge clock);
      if (i == n - 1 && n <= DEPTH) pushBurst(fr, n, c + 3);
`ifdef RANGE_SEQ_TRUNC_EN
      if (n > DEPTH && i == DEPTH - 1) pushBurst(fr, DEPTH, c + 3);
`endif
      i++;
    end
  endtask

  task automatic runFrame(input sample_t fr[$], input int gap_mode);
    bit ok;
    bit oversize;
    applyStimulus(fr, gap_mode, ok);
    if (!ok) return;
    oversize = (fr.size() > DEPTH);
    if (oversize && model_drops < 255) model_drops++;
    @(negedge clock);
    checkOutput("drop", 32'(drop), 32'(oversize));
    checkOutput("drop_count", 32'(drop_count), 32'(model_drops));
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Monitor: every cycle the outputs either match the scoreboard head or sit idle at zero.
  always @(negedge clock) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checkOutput("burst_data", 32'(data_out), 32'(e.data));
        checkOutput("burst_go_finish", {30'd0, go, finish}, {30'd0, e.go, e.fin});
        popped++;
      end else begin
        checkOutput("idle_outputs", {14'd0, go, finish, data_out}, 32'd0);
      end
      if (busy) begin
        busy_run++;
      end else if (busy_run > 0) begin
        if (busy_q.size() == 0) checkOutput("busy_unexpected", 32'(busy_run), 32'd0);
        else checkOutput("busy_len", 32'(busy_run), 32'(busy_q.pop_front()));
        busy_run = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sample_t fr[$];
    int      p0;
    int      w;

    repeat (3) @(negedge clock);
    checkOutput("reset_go", 32'(go), 32'd0);
    checkOutput("reset_finish", 32'(finish), 32'd0);
    checkOutput("reset_data", 32'(data_out), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_drop", {23'd0, drop, drop_count}, 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);

    $display("[TB] directed frames");
    fr = {16'd5, 16'd9, 16'd2};               runFrame(fr, 0);
    fr = {16'd7};                             runFrame(fr, 0);
    fr = {16'd1, 16'd2, 16'd3, 16'd4};        runFrame(fr, 0);
    fr = {16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15}; runFrame(fr, 0);
    fr = {16'd3, 16'd8};                      runFrame(fr, 0);
    fr = {16'd4, 16'd6, 16'd1};               runFrame(fr, 1);

    $display("[TB] reset during replay");
    p0 = popped;
    fr = {16'd11, 16'd22, 16'd33, 16'd44};
    runFrame(fr, 0);
    w = 0;
    while (popped < p0 + 2 && w < 50) begin
      @(posedge clock);
      w++;
    end
    checkOutput("reset_test_progress", 32'(popped >= p0 + 2), 32'd1);
    #2 reset = 1'b1;
    sb.delete();
    busy_q.delete();
    model_drops = 0;
    #1;
    checkOutput("midreset_outputs", {14'd0, go, finish, data_out}, 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("postreset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("postreset_drop_count", 32'(drop_count), 32'd0);
    fr = {16'd2, 16'd3};
    runFrame(fr, 0);

    $display("[TB] random frames");
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, DEPTH + 3);
      fr.delete();
      for (int k = 0; k < n; k++) fr.push_back(sample_t'($urandom_range(1, 16'hFFFF)));
      runFrame(fr, $urandom_range(0, 2));
    end

    w = 0;
    while (sb.size() > 0 && w < 100) begin
      @(negedge clock);
      w++;
    end
    repeat (5) @(negedge clock);
    checkOutput("drain_left", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
